// File: rtl/stall_ctrl_if.sv
// Decode-side request and stall/flush control bundle between the pipeline and stall_ctrl.
// master = pipeline side (drives the decode, branch and memory status); slave = stall_ctrl.
interface stall_ctrl_if;
    logic       id_valid;
    logic [2:0] id_rs;
    logic       id_rs_use;
    logic [2:0] id_rt;
    logic       id_rt_use;
    logic [2:0] id_rd;
    logic       id_regwrt;
    logic       br_taken;
    logic       mem_busy;
    logic       stall_pc;
    logic       stall_ifid;
    logic       nop_id;
    logic       flush_ifid;
    logic       freeze;
    logic       err;
    logic [1:0] state;

    modport master (
        output id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_rd, id_regwrt,
               br_taken, mem_busy,
        input  stall_pc, stall_ifid, nop_id, flush_ifid, freeze, err, state
    );

    modport slave (
        input  id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_rd, id_regwrt,
               br_taken, mem_busy,
        output stall_pc, stall_ifid, nop_id, flush_ifid, freeze, err, state
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: EX/MEM destination scoreboard, branch flush, memory-wait freeze, watchdog.
// Control outputs are combinational (zero latency); while memory is busy the whole pipeline is frozen.
module stall_ctrl #(
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    stall_ctrl_if.slave sc
);

    localparam logic [1:0] RUN  = 2'b00;
    localparam logic [1:0] HAZ  = 2'b01;
    localparam logic [1:0] MEMW = 2'b10;
    localparam logic [1:0] ERR  = 2'b11;

    logic [1:0] state_q, state_nxt;
    logic [7:0] wd_cnt, wd_cnt_nxt;
    logic       err_q;
    logic       ex_vld, mem_vld;
    logic [2:0] ex_rd, mem_rd;
    logic       rs_hit, rt_hit, hazard;
    logic       stall_pc, stall_ifid, nop_id, flush_ifid, freeze;

    assign rs_hit = (ex_vld && ex_rd == sc.id_rs) || (mem_vld && mem_rd == sc.id_rs);
    assign rt_hit = (ex_vld && ex_rd == sc.id_rt) || (mem_vld && mem_rd == sc.id_rt);
    assign hazard = sc.id_valid && ((sc.id_rs_use && rs_hit) || (sc.id_rt_use && rt_hit));

    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        nop_id     = 1'b0;
        flush_ifid = 1'b0;
        freeze     = 1'b0;
        state_nxt  = state_q;
        wd_cnt_nxt = wd_cnt;
        if (!rst) begin
            case (state_q)
                RUN, HAZ: begin
                    if (sc.mem_busy) begin
                        freeze     = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        wd_cnt_nxt = 8'd1;
                        state_nxt  = MEMW;
                    end else if (sc.br_taken) begin
                        flush_ifid = 1'b1;
                        nop_id     = 1'b1;
                        state_nxt  = RUN;
                    end else if (hazard) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        nop_id     = 1'b1;
                        state_nxt  = HAZ;
                    end else begin
                        state_nxt  = RUN;
                    end
                end
                MEMW: begin
                    if (sc.mem_busy) begin
                        freeze     = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        if (wd_cnt == 8'(WD_LIMIT)) state_nxt = ERR;
                        else                        wd_cnt_nxt = wd_cnt + 8'd1;
                    end else begin
                        // Memory done: pipeline advances this cycle, so the held branch or hazard acts now.
                        state_nxt  = RUN;
                        wd_cnt_nxt = 8'd0;
                        if (sc.br_taken) begin
                            flush_ifid = 1'b1;
                            nop_id     = 1'b1;
                        end else if (hazard) begin
                            stall_pc   = 1'b1;
                            stall_ifid = 1'b1;
                            nop_id     = 1'b1;
                        end
                    end
                end
                default: begin
                    freeze     = 1'b1;
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wd_cnt  <= 8'd0;
            err_q   <= 1'b0;
            ex_vld  <= 1'b0;
            ex_rd   <= 3'd0;
            mem_vld <= 1'b0;
            mem_rd  <= 3'd0;
        end else begin
            state_q <= state_nxt;
            wd_cnt  <= wd_cnt_nxt;
            err_q   <= (state_nxt == ERR);
            if (!freeze) begin
                mem_vld <= ex_vld;
                mem_rd  <= ex_rd;
                ex_vld  <= sc.id_valid && sc.id_regwrt && !nop_id;
                ex_rd   <= sc.id_rd;
            end
        end
    end

    assign sc.stall_pc   = stall_pc;
    assign sc.stall_ifid = stall_ifid;
    assign sc.nop_id     = nop_id;
    assign sc.flush_ifid = flush_ifid;
    assign sc.freeze     = freeze;
    assign sc.err        = err_q;
    assign sc.state      = state_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: table of single-cycle vectors plus hand sequences for memory wait,
// branch held across a wait, reset recovery and the watchdog (second instance, WD_LIMIT=4).
module tb_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stall_ctrl_if m_if();
    stall_ctrl_if w_if();

    stall_ctrl dut (.clk(clk), .rst(rst), .sc(m_if.slave));
    stall_ctrl #(.WD_LIMIT(4)) wdut (.clk(clk), .rst(rst), .sc(w_if.slave));

    // expected-output byte: {stall_pc, stall_ifid, nop_id, flush_ifid, freeze, err, state[1:0]}
    localparam logic [7:0] O_SP  = 8'h80;
    localparam logic [7:0] O_SI  = 8'h40;
    localparam logic [7:0] O_NOP = 8'h20;
    localparam logic [7:0] O_FL  = 8'h10;
    localparam logic [7:0] O_FZ  = 8'h08;
    localparam logic [7:0] O_ERR = 8'h04;
    localparam logic [7:0] S_RUN = 8'h00;
    localparam logic [7:0] S_HAZ = 8'h01;
    localparam logic [7:0] S_MW  = 8'h02;
    localparam logic [7:0] S_ERR = 8'h03;
    localparam logic [7:0] STALL = O_SP | O_SI | O_NOP;
    localparam logic [7:0] FRZ   = O_FZ | O_SP | O_SI;
    localparam logic [7:0] BRF   = O_FL | O_NOP;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [2:0] rs;
        logic       rsu;
        logic [2:0] rt;
        logic       rtu;
        logic [2:0] rd;
        logic       wr;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [7:0] mask;
        logic [7:0] exp;
        int         tag;
    } sb_t;

    sb_t  sbq[$];
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[20];

    function automatic stim_t st(input logic r, input logic v, input logic [2:0] rs, input logic rsu,
                                 input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                                 input logic wr, input logic br, input logic busy);
        stim_t s;
        s.rst = r; s.vld = v; s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu;
        s.rd = rd; s.wr = wr; s.br = br; s.busy = busy;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic [7:0] e);
        vec_t v;
        v.s = s;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] obs_m();
        return {m_if.stall_pc, m_if.stall_ifid, m_if.nop_id, m_if.flush_ifid,
                m_if.freeze, m_if.err, m_if.state};
    endfunction

    function automatic logic [7:0] obs_w();
        return {w_if.stall_pc, w_if.stall_ifid, w_if.nop_id, w_if.flush_ifid,
                w_if.freeze, w_if.err, w_if.state};
    endfunction

    task automatic drive(input stim_t s);
        rst            = s.rst;
        m_if.id_valid  = s.vld;  w_if.id_valid  = s.vld;
        m_if.id_rs     = s.rs;   w_if.id_rs     = s.rs;
        m_if.id_rs_use = s.rsu;  w_if.id_rs_use = s.rsu;
        m_if.id_rt     = s.rt;   w_if.id_rt     = s.rt;
        m_if.id_rt_use = s.rtu;  w_if.id_rt_use = s.rtu;
        m_if.id_rd     = s.rd;   w_if.id_rd     = s.rd;
        m_if.id_regwrt = s.wr;   w_if.id_regwrt = s.wr;
        m_if.br_taken  = s.br;   w_if.br_taken  = s.br;
        m_if.mem_busy  = s.busy; w_if.mem_busy  = s.busy;
    endtask

    task automatic compare();
        sb_t        e;
        logic [7:0] obs;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: no expected entry queued");
            return;
        end
        e   = sbq.pop_front();
        obs = e.sel ? obs_w() : obs_m();
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
            fails++;
            $display("FAIL %s tag=%0d got=%b want=%b mask=%b",
                     e.sel ? "wdog" : "main", e.tag, obs, e.exp, e.mask);
        end
    endtask

    task automatic step(input stim_t s, input bit sel, input logic [7:0] mask,
                        input logic [7:0] exp, input int tag);
        sb_t e;
        @(posedge clk);
        #1;
        drive(s);
        e.sel = sel; e.mask = mask; e.exp = exp; e.tag = tag;
        sbq.push_back(e);
        @(negedge clk);
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t idle;
        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // args: rst vld rs rsu rt rtu rd wr br busy
        tbl[0]  = mkv(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), S_RUN);
        tbl[1]  = mkv(st(1, 1, 3, 1, 3, 1, 3, 1, 1, 1), S_RUN);
        tbl[2]  = mkv(st(0, 1, 0, 0, 0, 0, 3, 1, 0, 0), S_RUN);
        tbl[3]  = mkv(st(0, 1, 3, 1, 0, 0, 4, 1, 0, 0), STALL | S_RUN);
        tbl[4]  = mkv(st(0, 1, 3, 1, 0, 0, 4, 1, 0, 0), STALL | S_HAZ);
        tbl[5]  = mkv(st(0, 1, 3, 1, 0, 0, 4, 1, 0, 0), S_HAZ);
        tbl[6]  = mkv(st(0, 1, 0, 0, 0, 0, 2, 1, 0, 0), S_RUN);
        tbl[7]  = mkv(st(0, 1, 0, 0, 0, 0, 5, 0, 0, 0), S_RUN);
        tbl[8]  = mkv(st(0, 1, 0, 0, 0, 0, 6, 0, 0, 0), S_RUN);
        tbl[9]  = mkv(st(0, 1, 5, 1, 2, 1, 7, 0, 0, 0), S_RUN);
        tbl[10] = mkv(st(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), S_RUN);
        tbl[11] = mkv(st(0, 1, 1, 0, 1, 0, 0, 0, 0, 0), S_RUN);
        tbl[12] = mkv(st(0, 0, 1, 1, 1, 1, 0, 1, 0, 0), S_RUN);
        tbl[13] = mkv(st(0, 1, 0, 0, 0, 0, 6, 1, 0, 0), S_RUN);
        tbl[14] = mkv(st(0, 1, 0, 0, 6, 1, 3, 1, 0, 0), STALL | S_RUN);
        tbl[15] = mkv(st(0, 1, 0, 0, 6, 1, 3, 1, 1, 0), BRF | S_HAZ);
        tbl[16] = mkv(st(0, 1, 0, 0, 0, 0, 5, 1, 0, 0), S_RUN);
        tbl[17] = mkv(st(0, 1, 5, 1, 0, 0, 0, 0, 1, 0), BRF | S_RUN);
        tbl[18] = mkv(st(0, 1, 5, 1, 0, 0, 0, 0, 0, 0), STALL | S_RUN);
        tbl[19] = mkv(st(0, 1, 5, 1, 0, 0, 0, 0, 0, 0), S_HAZ);

        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++)
            step(tbl[i].s, 1'b0, 8'hFF, tbl[i].exp, i);

        // memory wait: r3 sits in EX; writer of r7 must not enter the scoreboard while frozen
        step(st(0, 1, 0, 0, 0, 0, 3, 1, 0, 0), 1'b0, 8'hFF, S_RUN, 100);
        for (int k = 1; k <= 5; k++)
            step(st(0, 1, 0, 0, 0, 0, 7, 1, 0, 1), 1'b0, 8'hFF, FRZ | ((k == 1) ? S_RUN : S_MW), 100 + k);
        step(idle, 1'b0, 8'hFF, S_MW, 106);
        step(st(0, 1, 3, 1, 0, 0, 0, 0, 0, 0), 1'b0, 8'hFF, STALL | S_RUN, 107);
        step(idle, 1'b0, 8'hFF, S_HAZ, 108);
        step(idle, 1'b0, 8'hFF, S_RUN, 109);

        // branch coincident with memory wait: frozen, then flushed when memory completes
        for (int k = 1; k <= 3; k++)
            step(st(0, 1, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, 8'hFF, FRZ | ((k == 1) ? S_RUN : S_MW), 200 + k);
        step(st(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 8'hFF, BRF | S_MW, 204);
        step(idle, 1'b0, 8'hFF, S_RUN, 205);

        // reset mid-MEMW clears state and scoreboard
        step(st(0, 1, 0, 0, 0, 0, 4, 1, 0, 0), 1'b0, 8'hFF, S_RUN, 299);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 8'hFF, FRZ | S_RUN, 300);
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 8'hFF, S_MW, 301);
        step(st(0, 1, 4, 1, 0, 0, 0, 0, 0, 0), 1'b0, 8'hFF, S_RUN, 302);

        // watchdog on the WD_LIMIT=4 instance
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hF8, 8'h00, 400);
        for (int k = 1; k <= 11; k++) begin
            if (k == 1)
                step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 8'hFF, FRZ | S_RUN, 400 + k);
            else if (k <= 4)
                step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 8'hFF, FRZ | S_MW, 400 + k);
            else if (k == 5)
                step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, FRZ, FRZ, 400 + k);
            else if (k <= 9)
                step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 8'hFF, FRZ | O_ERR | S_ERR, 400 + k);
            else
                step(st(0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1'b1, 8'hFF, FRZ | O_ERR | S_ERR, 400 + k);
        end
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hF8, 8'h00, 420);
        step(idle, 1'b1, 8'hFF, S_RUN, 421);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
